// File: rtl/mux_4_32_rr_arbiter.sv
// Round-robin burst arbiter for a shared 4:1 x 32-bit tri-state mux. One requester
// owns the bus for a burst; ownership rotates on the burst's final beat or on abort.

module mux_4_32_rr_lane #(
  parameter int W = 32
) (
  input  logic         hit,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = din & {W{hit}};
endmodule

module mux_4_32_rr_arbiter #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [31:0] data_0,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [31:0] data_3,
  input  logic        out_ready,
  output logic [3:0]  gnt,
  output logic [1:0]  select,
  output logic        enable,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] gnt_q, gnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 en_q, en_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_LANES-1:0][VEC_W-1:0] data_a;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_d;
  logic [VEC_W-1:0]                mux_or;

  logic       cur_req, cur_last, xfer, end_grant, any_req;
  logic [1:0] pick_idle, pick_end;

  assign data_a = {data_3, data_2, data_1, data_0};

  // AND-OR mux: gnt is one-hot or zero, so at most one lane contributes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mux_4_32_rr_lane #(.W(VEC_W)) u_lane (
      .hit  (gnt_q[i]),
      .din  (data_a[i]),
      .dout (lane_d[i])
    );
  end

  always_comb begin
    mux_or = '0;
    for (int i = 0; i < NUM_LANES; i++) mux_or = mux_or | lane_d[i];
  end

  // First set bit searching from ptr+1 upward; ptr itself is lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign cur_req   = req[sel_q];
  assign cur_last  = last[sel_q];
  assign any_req   = |req;
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_end  = rr_pick(req, sel_q);

  assign out_valid = en_q & cur_req;
  assign out_last  = out_valid & (cur_last | (cnt_q == LAST_CNT));
  assign xfer      = out_valid & out_ready;
  // A dropped request ends the grant without forwarding anything.
  assign end_grant = (xfer & out_last) | (en_q & ~cur_req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = pick_idle;
          gnt_d   = 4'b0001 << pick_idle;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (end_grant) begin
          ptr_d = sel_q;
          cnt_d = '0;
          if (any_req) begin
            sel_d = pick_end;
            gnt_d = 4'b0001 << pick_end;
          end else begin
            state_d = IDLE;
            sel_d   = 2'd0;
            gnt_d   = '0;
            en_d    = 1'b0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = 2'd0;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign select   = sel_q;
  assign enable   = en_q;
  assign busy     = en_q;
  assign out_data = en_q ? mux_or : 'z;

endmodule

// File: doc/mux_4_32_rr_arbiter.md
Name: mux_4_32_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-to-1, 32-bit tri-stated data mux.
- Four requesters each present a 32-bit word stream with per-beat last.
- The block grants one requester at a time, drives the mux select/enable, and forwards the granted stream to a single valid/ready consumer.
- A grant is held for a whole burst (up to MAX_BEATS beats); fairness rotates on burst end.

Parameters:
- MAX_BEATS, 16, max beats per grant before forced release; legal range 1..256.
- CNT_W, 8, beat counter width; must satisfy 2^CNT_W >= MAX_BEATS.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  per-requester request/valid; bit i belongs to data_i
- last  input  4  per-requester end-of-burst marker; bit i is meaningful only with req[i]
- data_0..data_3  input  32 each  requester words
- out_ready  input  1  consumer accepts a beat
- gnt  output  4  one-hot grant, registered
- select  output  2  mux select, registered, encodes gnt
- enable  output  1  mux/bus drive enable, registered; 1 only while granted
- out_data  output  32  data of granted requester when enable=1, else 32'bz
- out_valid  output  1  req[select] & enable
- out_last  output  1  beat is final for this grant (natural or forced)
- busy  output  1  equals enable

Behaviour:
- Reset values (sync, rst=1 at a clk edge):
  - state=IDLE, gnt=4'b0000, select=2'd0, enable=0, beat_cnt=0.
  - rr_ptr=3, so requester 0 has highest priority first.
  - out_data=z, out_valid=0, out_last=0.
- A reset mid-burst aborts immediately; no further beats are forwarded.
- States:
  - IDLE: gnt=0, enable=0.
  - GRANT: exactly one gnt bit set, enable=1.
- Arbitration function:
  - Search req starting at rr_ptr+1 mod 4, wrapping; pick the first set bit.
  - Purely combinational; the result is registered into gnt/select.
- IDLE -> GRANT: if req!=0 at edge N, gnt/select/enable are valid from N+1.
  - Latency is 1 cycle from req to grant; beat_cnt=0 on entry.
- GRANT transfer: a beat moves when out_valid & out_ready; beat_cnt increments per transfer.
- out_last = last[select] | (beat_cnt == MAX_BEATS-1), qualified by out_valid.
- End of grant on a transfer with out_last=1:
  - rr_ptr <= select.
  - If any req bit is set in that cycle, re-arbitrate with the updated pointer. The current requester is lowest priority. Stay in GRANT with the new gnt at the next edge (no bubble) and beat_cnt=0.
  - Else go to IDLE.
- Abort: if req[select]=0 while in GRANT with no transfer, treat as end of grant.
  - Same rules as above; rr_ptr <= select. No beat is forwarded that cycle.
- Backpressure: with out_ready=0, the grant, select and beat_cnt are held indefinitely. last and data are sampled only on transfer.
- Simultaneous requests: the arbitration function alone decides. Non-granted requesters see no gnt and must hold req.
- Single requester continuously requesting: it is re-granted back-to-back after each burst, with no idle cycle.
- MAX_BEATS=1: every beat is out_last; the grant rotates each beat.
- select/gnt never change while enable=1 except at an end-of-grant edge.
- gnt is always one-hot or zero.

Test Plan:
- Reset then req=4'b1111, last=4'b1111, out_ready=1 → grants 0,1,2,3,0 on consecutive cycles. First gnt=4'b0001 one cycle after req. enable stays 1 throughout.
- req[2] only, 3-beat burst (last on beat 3), data_2=32'hA5A5_0001..0003 → out_data sequence matches, out_last on beat 3. Then IDLE with enable=0 and out_data=z.
- MAX_BEATS=4, req[1] held with last=0 for 10 beats, req[3]=1 → forced out_last on beat 4, then gnt=4'b1000.
- out_ready=0 for 5 cycles mid-burst of requester 0 → out_data/select/beat_cnt stable; burst resumes with no lost or duplicated word.
- Requester 3 drops req mid-burst while req[0]=1 → abort, gnt=4'b0001 next cycle.
- rst asserted mid-burst → next cycle gnt=0, enable=0, out_data=z. After release with req=4'b1111, first grant is requester 0.
